// File: rtl/aq_axi_memcpy32_rd.sv
// AXI4 read-side memcpy engine: splits a byte-length read into INCR bursts
// that never cross a 4 KB boundary and streams the returned words into a FIFO.
module aq_axi_memcpy32_rd #(
    parameter int unsigned MAX_BURST = 16
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic        RD_START,
    input  logic [31:0] RD_ADRS,
    input  logic [31:0] RD_COUNT,
    output logic        RD_READY,

    output logic [31:0] M_AXI_ARADDR,
    output logic [7:0]  M_AXI_ARLEN,
    output logic [2:0]  M_AXI_ARSIZE,
    output logic [1:0]  M_AXI_ARBURST,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,

    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RLAST,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY,

    output logic        FIFO_WE,
    output logic [31:0] FIFO_WDATA,
    input  logic        FIFO_FULL,

    output logic        RD_ERR
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]  state;
    logic [31:0] addr;
    logic [30:0] remain;
    logic [8:0]  len;
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        rd_err;

    logic [30:0] start_beats;
    logic [8:0]  start_len;
    logic [31:0] next_addr;
    logic [30:0] next_remain;
    logic [8:0]  next_len;
    logic        rready;
    logic        beat_ok;

    // Burst length limited by remaining beats, MAX_BURST and the 4 KB page end.
    function automatic logic [8:0] calc_len(input logic [9:0] word_off,
                                            input logic [30:0] beats);
        logic [31:0] n;
        logic [31:0] to_bound;
        n        = {1'b0, beats};
        to_bound = 32'd1024 - {22'd0, word_off};
        if (n > MAX_BURST) n = MAX_BURST;
        if (n > to_bound)  n = to_bound;
        return 9'(n);
    endfunction

    always_comb begin
        start_beats = {1'b0, RD_COUNT[31:2]} + {30'd0, |RD_COUNT[1:0]};
        start_len   = calc_len(RD_ADRS[11:2], start_beats);
        next_addr   = addr + {21'd0, len, 2'b00};
        next_remain = remain - 31'd1;
        next_len    = calc_len(next_addr[11:2], next_remain);
        rready      = (state == DATA) && !FIFO_FULL;
        beat_ok     = M_AXI_RVALID && rready;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            addr    <= '0;
            remain  <= '0;
            len     <= '0;
            arvalid <= 1'b0;
            araddr  <= '0;
            arlen   <= '0;
            rd_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (RD_START) begin
                        rd_err <= 1'b0;
                        addr   <= RD_ADRS;
                        remain <= start_beats;
                        if (start_beats != '0) begin
                            state   <= ADDR;
                            arvalid <= 1'b1;
                            araddr  <= RD_ADRS;
                            len     <= start_len;
                            arlen   <= 8'(start_len - 9'd1);
                        end
                    end
                end
                ADDR: begin
                    if (M_AXI_ARREADY) begin
                        arvalid <= 1'b0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (beat_ok) begin
                        remain <= next_remain;
                        if (M_AXI_RRESP != 2'b00) rd_err <= 1'b1;
                        if (M_AXI_RLAST) begin
                            if (next_remain == '0) begin
                                state <= IDLE;
                            end else begin
                                state   <= ADDR;
                                addr    <= next_addr;
                                arvalid <= 1'b1;
                                araddr  <= next_addr;
                                len     <= next_len;
                                arlen   <= 8'(next_len - 9'd1);
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign RD_READY      = (state == IDLE);
    assign M_AXI_ARADDR  = araddr;
    assign M_AXI_ARLEN   = arlen;
    assign M_AXI_ARSIZE  = 3'b010;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARVALID = arvalid;
    assign M_AXI_RREADY  = rready;
    assign FIFO_WE       = beat_ok;
    assign FIFO_WDATA    = M_AXI_RDATA;
    assign RD_ERR        = rd_err;

endmodule

// File: tb/tb_aq_axi_memcpy32_rd.sv
// Bench for aq_axi_memcpy32_rd: randomised AXI slave and FIFO back-pressure,
// expected AR sequence and data stream computed from burst-splitting rules.
module tb_aq_axi_memcpy32_rd;

    localparam int unsigned MB = 16;

    logic        CLK;
    logic        RST;
    logic        RD_START;
    logic [31:0] RD_ADRS;
    logic [31:0] RD_COUNT;
    logic        RD_READY;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        FIFO_WE;
    logic [31:0] FIFO_WDATA;
    logic        RD_ERR;
    logic        full_rand;
    logic        full_force;
    logic        rand_full_en;
    logic [31:0] err_addr;

    int vectors;
    int miscompares;

    logic [31:0] ar_q[$];
    logic [7:0]  arlen_q[$];
    logic [31:0] data_q[$];
    logic [31:0] exp_addr[$];
    logic [7:0]  exp_len[$];
    logic [31:0] exp_data[$];

    logic        ar_hs;
    logic        r_hs;
    logic [31:0] hs_addr;
    logic [7:0]  hs_len;
    logic        prev_wait;
    logic [31:0] prev_addr;
    logic [7:0]  prev_len;

    aq_axi_memcpy32_rd #(.MAX_BURST(MB)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .RD_START      (RD_START),
        .RD_ADRS       (RD_ADRS),
        .RD_COUNT      (RD_COUNT),
        .RD_READY      (RD_READY),
        .M_AXI_ARADDR  (ARADDR),
        .M_AXI_ARLEN   (ARLEN),
        .M_AXI_ARSIZE  (ARSIZE),
        .M_AXI_ARBURST (ARBURST),
        .M_AXI_ARVALID (ARVALID),
        .M_AXI_ARREADY (ARREADY),
        .M_AXI_RDATA   (RDATA),
        .M_AXI_RRESP   (RRESP),
        .M_AXI_RLAST   (RLAST),
        .M_AXI_RVALID  (RVALID),
        .M_AXI_RREADY  (RREADY),
        .FIFO_WE       (FIFO_WE),
        .FIFO_WDATA    (FIFO_WDATA),
        .FIFO_FULL     (full_rand | full_force),
        .RD_ERR        (RD_ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Monitor: samples on the falling edge, i.e. the values the next rising edge will act on.
    always @(negedge CLK) begin
        ar_hs   = !RST && ARVALID && ARREADY;
        r_hs    = !RST && RVALID && RREADY;
        hs_addr = ARADDR;
        hs_len  = ARLEN;
        if (ar_hs) begin
            ar_q.push_back(ARADDR);
            arlen_q.push_back(ARLEN);
        end
        if (!RST) begin
            chk1("fifo_we_is_handshake", FIFO_WE, RVALID & RREADY);
            if (FIFO_WE) begin
                data_q.push_back(FIFO_WDATA);
                chk32("wdata_passthru", FIFO_WDATA, RDATA);
            end
            if (full_rand | full_force) chk1("rready_when_full", RREADY, 1'b0);
            if (ARVALID) begin
                chk32("arsize", 32'(ARSIZE), 32'd2);
                chk32("arburst", 32'(ARBURST), 32'd1);
            end
            if (prev_wait) begin
                chk1("ar_hold_valid", ARVALID, 1'b1);
                chk32("ar_hold_addr", ARADDR, prev_addr);
                chk32("ar_hold_len", 32'(ARLEN), 32'(prev_len));
            end
        end
        prev_wait = !RST && ARVALID && !ARREADY;
        prev_addr = ARADDR;
        prev_len  = ARLEN;
    end

    // AXI read slave with random AR/R timing; data derived from the beat address.
    initial begin : slave
        logic [31:0] pend_a[$];
        logic [7:0]  pend_l[$];
        int unsigned beat;
        logic [31:0] a;
        beat    = 0;
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        RDATA   = '0;
        RRESP   = '0;
        RLAST   = 1'b0;
        forever begin
            @(posedge CLK);
            #2;
            if (RST) begin
                pend_a.delete();
                pend_l.delete();
                beat    = 0;
                ARREADY = 1'b0;
                RVALID  = 1'b0;
                RLAST   = 1'b0;
            end else begin
                if (ar_hs) begin
                    pend_a.push_back(hs_addr);
                    pend_l.push_back(hs_len);
                end
                if (r_hs && pend_a.size() > 0) begin
                    if (beat == 32'(pend_l[0])) begin
                        void'(pend_a.pop_front());
                        void'(pend_l.pop_front());
                        beat = 0;
                    end else begin
                        beat++;
                    end
                end
                ARREADY = ($urandom_range(0, 2) != 0);
                if (!(RVALID && !r_hs)) begin
                    if (pend_a.size() > 0 && $urandom_range(0, 3) != 0) begin
                        a      = pend_a[0] + 32'(4 * beat);
                        RVALID = 1'b1;
                        RDATA  = mem_word(a);
                        RRESP  = (a == err_addr) ? 2'b10 : 2'b00;
                        RLAST  = (beat == 32'(pend_l[0]));
                    end else begin
                        RVALID = 1'b0;
                        RLAST  = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        full_rand = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            full_rand = rand_full_en && ($urandom_range(0, 3) == 0);
        end
    end

    // Reference: split into bursts of min(remaining, MB, words left in the 4 KB page).
    task automatic build_model(input logic [31:0] adrs, input logic [31:0] cnt);
        logic [31:0] a;
        int unsigned rem;
        int unsigned len;
        int unsigned bnd;
        exp_addr.delete();
        exp_len.delete();
        exp_data.delete();
        a   = adrs;
        rem = cnt / 4;
        if (cnt % 4 != 0) rem++;
        while (rem > 0) begin
            bnd = (4096 - (a % 4096)) / 4;
            len = rem;
            if (len > MB)  len = MB;
            if (len > bnd) len = bnd;
            exp_addr.push_back(a);
            exp_len.push_back(8'(len - 1));
            for (int unsigned i = 0; i < len; i++) exp_data.push_back(mem_word(a + 32'(4 * i)));
            a   = a + 32'(4 * len);
            rem = rem - len;
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!RD_READY && k < 3000) begin
            @(negedge CLK);
            k++;
        end
        chk1("ready_before_start", RD_READY, 1'b1);
    endtask

    task automatic start_cmd(input logic [31:0] adrs, input logic [31:0] cnt);
        wait_ready();
        @(posedge CLK);
        #1;
        RD_START = 1'b1;
        RD_ADRS  = adrs;
        RD_COUNT = cnt;
        @(posedge CLK);
        #1;
        RD_START = 1'b0;
    endtask

    task automatic run_cmd(input logic [31:0] adrs, input logic [31:0] cnt, input int stall_at);
        int nar;
        int nd;
        int n;
        int budget;
        int beats;
        logic stalled;
        build_model(adrs, cnt);
        beats   = exp_data.size();
        stalled = 1'b0;
        nar     = ar_q.size();
        nd      = data_q.size();
        start_cmd(adrs, cnt);
        @(negedge CLK);
        chk1("arvalid_after_start", ARVALID, beats != 0);
        chk1("ready_after_start", RD_READY, beats == 0);
        chk1("err_cleared_on_start", RD_ERR, 1'b0);
        if (beats == 0) begin
            repeat (8) begin
                @(negedge CLK);
                chk1("zero_len_no_ar", ARVALID, 1'b0);
                chk1("zero_len_ready", RD_READY, 1'b1);
            end
            chk32("zero_len_ar_count", 32'(ar_q.size() - nar), 32'd0);
            return;
        end
        n      = 0;
        budget = 0;
        while (n < beats && budget < 20000) begin
            @(negedge CLK);
            budget++;
            if (FIFO_WE) n++;
            if (stall_at >= 0 && !stalled && n == stall_at) begin
                stalled = 1'b1;
                @(posedge CLK);
                #1;
                full_force = 1'b1;
                RD_START   = 1'b1;
                RD_ADRS    = 32'h0000_8000;
                RD_COUNT   = 32'd4;
                @(negedge CLK);
                chk1("stall_rready", RREADY, 1'b0);
                chk1("stall_fifo_we", FIFO_WE, 1'b0);
                @(posedge CLK);
                #1;
                RD_START = 1'b0;
                repeat (4) begin
                    @(negedge CLK);
                    chk1("stall_rready", RREADY, 1'b0);
                    chk1("stall_fifo_we", FIFO_WE, 1'b0);
                end
                @(posedge CLK);
                #1;
                full_force = 1'b0;
            end
        end
        chk32("beat_count", 32'(n), 32'(beats));
        @(negedge CLK);
        chk1("ready_after_last", RD_READY, 1'b1);
        chk32("ar_count", 32'(ar_q.size() - nar), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (nar + i < ar_q.size()) begin
                chk32("ar_addr", ar_q[nar + i], exp_addr[i]);
                chk32("ar_len", 32'(arlen_q[nar + i]), 32'(exp_len[i]));
            end
        end
        chk32("data_count", 32'(data_q.size() - nd), 32'(beats));
        for (int i = 0; i < beats; i++) begin
            if (nd + i < data_q.size()) chk32("fifo_data", data_q[nd + i], exp_data[i]);
        end
    endtask

    initial begin : main
        int nar;
        int nd;
        int k;
        vectors      = 0;
        miscompares  = 0;
        RST          = 1'b1;
        RD_START     = 1'b0;
        RD_ADRS      = '0;
        RD_COUNT     = '0;
        full_force   = 1'b0;
        rand_full_en = 1'b0;
        err_addr     = 32'hFFFF_FFF0;

        @(negedge CLK);
        chk1("rst_ready", RD_READY, 1'b1);
        chk1("rst_arvalid", ARVALID, 1'b0);
        chk1("rst_rready", RREADY, 1'b0);
        chk1("rst_fifo_we", FIFO_WE, 1'b0);
        chk1("rst_rd_err", RD_ERR, 1'b0);
        chk32("rst_araddr", ARADDR, 32'd0);
        chk32("rst_arlen", 32'(ARLEN), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        run_cmd(32'h0000_1000, 32'd64, -1);
        run_cmd(32'h0000_0000, 32'd200, -1);
        run_cmd(32'h0000_0FF8, 32'd64, -1);
        run_cmd(32'h0000_2000, 32'd64, 5);
        run_cmd(32'h0000_0400, 32'd0, -1);
        run_cmd(32'h0000_0500, 32'd6, -1);

        err_addr = 32'h0000_3008;
        run_cmd(32'h0000_3000, 32'd64, -1);
        chk1("err_set", RD_ERR, 1'b1);
        repeat (5) @(negedge CLK);
        chk1("err_sticky", RD_ERR, 1'b1);
        err_addr = 32'hFFFF_FFF0;
        run_cmd(32'h0000_3100, 32'd20, -1);
        chk1("err_clean_cmd", RD_ERR, 1'b0);

        // Reset pulse in the middle of a multi-burst read.
        nd = data_q.size();
        start_cmd(32'h0000_0000, 32'd256);
        k = 0;
        while (data_q.size() < nd + 20 && k < 2000) begin
            @(negedge CLK);
            k++;
        end
        chk1("reset_test_progress", data_q.size() >= nd + 20, 1'b1);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        chk1("midrst_ready", RD_READY, 1'b1);
        chk1("midrst_arvalid", ARVALID, 1'b0);
        chk1("midrst_rready", RREADY, 1'b0);
        chk1("midrst_fifo_we", FIFO_WE, 1'b0);
        chk32("midrst_araddr", ARADDR, 32'd0);
        chk32("midrst_arlen", 32'(ARLEN), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        nar = ar_q.size();
        nd  = data_q.size();
        repeat (6) @(negedge CLK);
        chk32("post_rst_no_ar", 32'(ar_q.size() - nar), 32'd0);
        chk32("post_rst_no_data", 32'(data_q.size() - nd), 32'd0);
        chk1("post_rst_ready", RD_READY, 1'b1);

        rand_full_en = 1'b1;
        for (int t = 0; t < 10; t++) begin
            run_cmd({14'd0, 16'($urandom_range(0, 16'h3FFF)), 2'b00},
                    32'($urandom_range(0, 900)), -1);
        end
        rand_full_en = 1'b0;
        run_cmd(32'h0000_0FFC, 32'd12, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aq_axi_memcpy32_rd.md
AQ_AXI_MEMCPY32_RD -- requirements
Module: aq_axi_memcpy32_rd

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 16, meaning maximum beats per AXI read burst (power of 2, 1..256).
REQ-002 The block SHALL have port CLK  input  1  single clock; all logic on its rising edge.
REQ-003 The block SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have ports RD_START  input  1  command pulse; RD_ADRS  input  32  byte source address, word-aligned; RD_COUNT  input  32  byte length.
REQ-005 The block SHALL have port RD_READY  output  1  high when idle and able to accept RD_START.
REQ-006 The block SHALL have ports M_AXI_ARADDR  output  32; M_AXI_ARLEN  output  8; M_AXI_ARSIZE  output  3; M_AXI_ARBURST  output  2; M_AXI_ARVALID  output  1; M_AXI_ARREADY  input  1.
REQ-007 The block SHALL have ports M_AXI_RDATA  input  32; M_AXI_RRESP  input  2; M_AXI_RLAST  input  1; M_AXI_RVALID  input  1; M_AXI_RREADY  output  1.
REQ-008 The block SHALL have ports FIFO_WE  output  1; FIFO_WDATA  output  32; FIFO_FULL  input  1  write-side FIFO interface.
REQ-009 The block SHALL have port RD_ERR  output  1  sticky error flag for the current command.

Function
REQ-010 States SHALL be IDLE, ADDR, DATA; RD_READY = (state==IDLE).
REQ-011 In IDLE, RD_START SHALL capture address and beat count = RD_COUNT[31:2] + (RD_COUNT[1:0]!=0), and clear RD_ERR.
REQ-012 If the computed beat count is 0, state SHALL remain IDLE, with no AR issued and RD_READY held high.
REQ-013 Otherwise, RD_START at cycle N SHALL give ARVALID=1 and RD_READY=0 at cycle N+1 (state ADDR).
REQ-014 Burst length SHALL be min(remaining beats, MAX_BURST, beats to next 4 KB boundary); ARLEN = length-1.
REQ-015 ARSIZE SHALL be constantly 3'b010 and ARBURST constantly 2'b01 (INCR).
REQ-016 ARADDR, ARLEN and ARVALID SHALL be held stable until the ARREADY handshake; the handshake moves state to DATA and sets ARVALID=0 the next cycle.
REQ-017 In DATA, RREADY SHALL be !FIFO_FULL; RREADY SHALL be 0 in all other states.
REQ-018 FIFO_WE SHALL equal RVALID & RREADY combinationally, with FIFO_WDATA = RDATA in the same cycle; no beat is dropped or duplicated.
REQ-019 On the beat with RLAST: if remaining beats are 0, the next state SHALL be IDLE; otherwise, the address advances by 4*length and the next state is ADDR.
REQ-020 The burst SHALL end only on RLAST; the beat counter SHALL be decremented per accepted beat.
REQ-021 Any accepted beat with RRESP!=0 SHALL set RD_ERR=1, held until the next accepted RD_START; data is still pushed and the transfer completes.
REQ-022 RD_START while not IDLE SHALL be ignored.
REQ-023 Address arithmetic SHALL be 32-bit unsigned; wrap past 0xFFFFFFFF is not supported, and behaviour there is undefined.

Reset
REQ-024 While RST=1, state SHALL be IDLE; RD_READY=1; ARVALID, RREADY, FIFO_WE, RD_ERR=0; ARADDR=0; ARLEN=0.
REQ-025 RST asserted mid-transfer SHALL abort immediately, with no further AR or FIFO writes; the AXI slave and FIFO are reset by the same RST.

Verification
REQ-026 RD_ADRS=0x1000, RD_COUNT=64 -> one AR (ARADDR=0x1000, ARLEN=15), 16 FIFO_WE matching RDATA, RD_READY=1 the cycle after RLAST.
REQ-027 RD_ADRS=0x0, RD_COUNT=200 -> ARs at 0x00/0x40/0x80/0xC0 with ARLEN 15,15,15,1; 50 FIFO writes total.
REQ-028 RD_ADRS=0x0FF8, RD_COUNT=64 -> AR 0x0FF8 ARLEN=1, then AR 0x1000 ARLEN=13.
REQ-029 FIFO_FULL=1 for 5 cycles mid-burst -> RREADY=0 and FIFO_WE=0 throughout; all 16 beats delivered in order afterwards.
REQ-030 RD_COUNT=0 -> no ARVALID, RD_READY stays 1; RD_COUNT=6 -> ARLEN=1 (2 beats).
REQ-031 RRESP=2'b10 on beat 3 -> RD_ERR=1 until next RD_START, all beats still written; RST pulse mid-burst -> RD_READY=1, ARVALID=0 immediately.
